memory_arbiter: RTL and testbench

//  Shares the single SRAM request port of the memory manager between two requesters.
//  - Video scan-out reads: high priority, deadline bound.
//  - MCU pixel writes: posted through a small write FIFO.

---
 rtl/g76_mem_pkg.sv | 18 +
 rtl/mem_write_fifo.sv | 57 +++++
 rtl/memory_arbiter.sv | 138 +++++++++++++
 tb/tb_memory_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/g76_mem_pkg.sv
// Shared types and widths for the SRAM request arbiter and its write FIFO.
package g76_mem_pkg;

  localparam int ADDR_WIDTH = 17;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    VIDEO_READ = 2'd1,
    MCU_WRITE  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } write_entry_t;

endpackage

// File: rtl/mem_write_fifo.sv
// Show-ahead synchronous FIFO holding posted MCU writes until the arbiter
// grants them to the memory manager.
module mem_write_fifo
  import g76_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  write_entry_t       din,
  output write_entry_t       dout,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  write_entry_t entries [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic doPush;
  logic doPop;

  // Full/empty come from the registered count, so a push in the same cycle
  // as a pop still sees the pre-pop occupancy.
  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = entries[rdPtr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; stale entries are never visible once count is 0
  always_ff @(posedge clock) begin
    if (doPush) entries[wrPtr] <= din;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the single memory-manager request port between high-priority
// video scan-out reads and posted MCU writes, with a bounded video run so
// queued writes cannot starve.
module memory_arbiter
  import g76_mem_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_VIDEO_RUN = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vidReadRequest,
  input  logic [ADDR_WIDTH-1:0] vidAddress,
  output logic [DATA_WIDTH-1:0] vidReadData,
  output logic                  vidReadComplete,
  input  logic                  mcuWriteRequest,
  input  logic [ADDR_WIDTH-1:0] mcuAddress,
  input  logic [DATA_WIDTH-1:0] mcuWriteData,
  output logic                  mcuWriteAck,
  output logic                  mcuFifoFull,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic                  memoryReadRequest,
  output logic                  memoryWriteRequest,
  output logic [DATA_WIDTH-1:0] memoryWriteData,
  input  logic [DATA_WIDTH-1:0] memoryReadData,
  input  logic                  memoryReadComplete,
  input  logic                  memoryWriteComplete
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RUN_W = $clog2(MAX_VIDEO_RUN + 1);

  arb_state_t       state;
  arb_state_t       nextState;
  logic [RUN_W-1:0] runCount;
  logic             runLimit;
  logic             grantVideo;
  logic             grantMcu;
  logic             accepted;
  logic             fifoPush;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CNT_W-1:0] fifoCount;
  write_entry_t     fifoIn;
  write_entry_t     fifoHead;

  assign runLimit    = (runCount >= RUN_W'(MAX_VIDEO_RUN));
  // One push per request assertion: 'accepted' blocks re-pushing a held request.
  assign fifoPush    = mcuWriteRequest && !fifoFull && !accepted;
  assign fifoIn      = '{addr: mcuAddress, data: mcuWriteData};
  assign mcuFifoFull = fifoFull;

  mem_write_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) writeFifo (
    .clock (clock),
    .reset (reset),
    .push  (fifoPush),
    .pop   (grantMcu),
    .din   (fifoIn),
    .dout  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // Arbiter state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and grant decode; video wins unless it has used up its run with writes waiting
  always_comb begin
    nextState  = state;
    grantVideo = 1'b0;
    grantMcu   = 1'b0;
    case (state)
      IDLE: begin
        if (vidReadRequest && !(!fifoEmpty && runLimit)) begin
          grantVideo = 1'b1;
          nextState  = VIDEO_READ;
        end else if (!fifoEmpty) begin
          grantMcu  = 1'b1;
          nextState = MCU_WRITE;
        end
      end
      VIDEO_READ: if (memoryReadComplete)  nextState = IDLE;
      MCU_WRITE:  if (memoryWriteComplete) nextState = IDLE;
      default:    nextState = IDLE;
    endcase
  end

  // Memory-side request, address and write data, all loaded on grant
  always_ff @(posedge clock) begin
    if (!reset) begin
      memoryReadRequest  <= 1'b0;
      memoryWriteRequest <= 1'b0;
      memoryAddress      <= '0;
      memoryWriteData    <= '0;
    end else begin
      memoryReadRequest  <= (nextState == VIDEO_READ);
      memoryWriteRequest <= (nextState == MCU_WRITE);
      if (grantVideo) begin
        memoryAddress <= vidAddress;
      end else if (grantMcu) begin
        memoryAddress   <= fifoHead.addr;
        memoryWriteData <= fifoHead.data;
      end
    end
  end

  // Video read return: capture data and pulse complete for one cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      vidReadData     <= '0;
      vidReadComplete <= 1'b0;
    end else begin
      vidReadComplete <= (state == VIDEO_READ) && memoryReadComplete;
      if ((state == VIDEO_READ) && memoryReadComplete) vidReadData <= memoryReadData;
    end
  end

  // MCU accept/ack handshake and the saturating video run counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      mcuWriteAck <= 1'b0;
      accepted    <= 1'b0;
      runCount    <= '0;
    end else begin
      mcuWriteAck <= fifoPush;
      accepted    <= mcuWriteRequest && (accepted || fifoPush);
      if (grantMcu || (fifoCount == '0)) runCount <= '0;
      else if (grantVideo && !runLimit)  runCount <= runCount + RUN_W'(1);
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, video read, posted writes,
// starvation limit, single push per request and reset mid-write.
module tb_memory_arbiter;
  import g76_mem_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  vidReadRequest;
  logic [ADDR_WIDTH-1:0] vidAddress;
  logic [DATA_WIDTH-1:0] vidReadData;
  logic                  vidReadComplete;
  logic                  mcuWriteRequest;
  logic [ADDR_WIDTH-1:0] mcuAddress;
  logic [DATA_WIDTH-1:0] mcuWriteData;
  logic                  mcuWriteAck;
  logic                  mcuFifoFull;
  logic [ADDR_WIDTH-1:0] memoryAddress;
  logic                  memoryReadRequest;
  logic                  memoryWriteRequest;
  logic [DATA_WIDTH-1:0] memoryWriteData;
  logic [DATA_WIDTH-1:0] memoryReadData;
  logic                  memoryReadComplete;
  logic                  memoryWriteComplete;

  int total = 0;
  int bad   = 0;

  memory_arbiter dut (
    .clock               (clock),
    .reset               (reset),
    .vidReadRequest      (vidReadRequest),
    .vidAddress          (vidAddress),
    .vidReadData         (vidReadData),
    .vidReadComplete     (vidReadComplete),
    .mcuWriteRequest     (mcuWriteRequest),
    .mcuAddress          (mcuAddress),
    .mcuWriteData        (mcuWriteData),
    .mcuWriteAck         (mcuWriteAck),
    .mcuFifoFull         (mcuFifoFull),
    .memoryAddress       (memoryAddress),
    .memoryReadRequest   (memoryReadRequest),
    .memoryWriteRequest  (memoryWriteRequest),
    .memoryWriteData     (memoryWriteData),
    .memoryReadData      (memoryReadData),
    .memoryReadComplete  (memoryReadComplete),
    .memoryWriteComplete (memoryWriteComplete)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    vidReadRequest = 1'b0;
    vidAddress = '0;
    mcuWriteRequest = 1'b0;
    mcuAddress = '0;
    mcuWriteData = '0;
    memoryReadData = '0;
    memoryReadComplete = 1'b0;
    memoryWriteComplete = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    reset = 1'b0;
    vidReadRequest = 1'b1;
    vidAddress = 17'h01234;
    mcuWriteRequest = 1'b1;
    mcuAddress = 17'h00042;
    mcuWriteData = 8'h99;
    memoryReadData = 8'hEE;
    memoryReadComplete = 1'b0;
    memoryWriteComplete = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      outs = {memoryReadRequest, memoryWriteRequest, memoryAddress, memoryWriteData,
              vidReadData, vidReadComplete, mcuWriteAck, mcuFifoFull};
      total++;
      if (outs !== '0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", c, outs);
      end
    end
    reset = 1'b1;
    total++;
    if (memoryReadRequest !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_early: memoryReadRequest=%b want 0", memoryReadRequest);
    end
    tick();
    total++;
    if ({memoryReadRequest, memoryWriteRequest, memoryAddress} !== {1'b1, 1'b0, 17'h01234}) begin
      bad++;
      $display("FAIL reset_first_grant: rd=%b wr=%b addr=%h want rd=1 wr=0 addr=01234",
               memoryReadRequest, memoryWriteRequest, memoryAddress);
    end
    total++;
    if (mcuWriteAck !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_ack: got %b want 1", mcuWriteAck);
    end
  endtask

  task automatic test_video_only();
    do_reset();
    vidAddress = 17'h1ABCD;
    vidReadRequest = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({memoryReadRequest, memoryWriteRequest, memoryAddress} !== {1'b1, 1'b0, 17'h1ABCD}) begin
        bad++;
        $display("FAIL video_request cycle %0d: rd=%b wr=%b addr=%h want rd=1 wr=0 addr=1abcd",
                 c, memoryReadRequest, memoryWriteRequest, memoryAddress);
      end
    end
    memoryReadComplete = 1'b1;
    memoryReadData = 8'h5A;
    tick();
    memoryReadComplete = 1'b0;
    memoryReadData = 8'h00;
    total++;
    if ({memoryReadRequest, vidReadComplete, vidReadData} !== {1'b0, 1'b1, 8'h5A}) begin
      bad++;
      $display("FAIL video_complete: rd=%b cmpl=%b data=%h want rd=0 cmpl=1 data=5a",
               memoryReadRequest, vidReadComplete, vidReadData);
    end
    vidReadRequest = 1'b0;
    tick();
    total++;
    if ({memoryReadRequest, vidReadComplete, vidReadData} !== {1'b0, 1'b0, 8'h5A}) begin
      bad++;
      $display("FAIL video_pulse_end: rd=%b cmpl=%b data=%h want rd=0 cmpl=0 data=5a",
               memoryReadRequest, vidReadComplete, vidReadData);
    end
    memoryWriteComplete = 1'b1;
    memoryReadComplete = 1'b1;
    tick();
    memoryWriteComplete = 1'b0;
    memoryReadComplete = 1'b0;
    tick();
    total++;
    if ({memoryReadRequest, memoryWriteRequest, vidReadComplete} !== 3'b000 || dut.state !== IDLE) begin
      bad++;
      $display("FAIL video_spurious: rd=%b wr=%b cmpl=%b state=%0d want 0 0 0 IDLE",
               memoryReadRequest, memoryWriteRequest, vidReadComplete, dut.state);
    end
  endtask

  task automatic test_mcu_posted();
    do_reset();
    vidAddress = 17'h00100;
    vidReadRequest = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      mcuWriteRequest = 1'b1;
      mcuAddress = 17'(16 + i);
      mcuWriteData = 8'(i);
      tick();
      total++;
      if (mcuWriteAck !== 1'b1) begin
        bad++;
        $display("FAIL posted_ack %0d: got %b want 1", i, mcuWriteAck);
      end
      mcuWriteRequest = 1'b0;
      tick();
    end
    total++;
    if (mcuFifoFull !== 1'b1) begin
      bad++;
      $display("FAIL posted_full: got %b want 1", mcuFifoFull);
    end
    mcuWriteRequest = 1'b1;
    mcuAddress = 17'h00014;
    mcuWriteData = 8'd4;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (mcuWriteAck !== 1'b0) begin
        bad++;
        $display("FAIL posted_refused cycle %0d: ack=%b want 0", c, mcuWriteAck);
      end
    end
    memoryReadComplete = 1'b1;
    memoryReadData = 8'h33;
    tick();
    memoryReadComplete = 1'b0;
    vidReadRequest = 1'b0;
    tick();
    total++;
    if ({mcuWriteAck, memoryWriteRequest} !== 2'b01) begin
      bad++;
      $display("FAIL posted_pop_cycle: ack=%b wr=%b want ack=0 wr=1", mcuWriteAck, memoryWriteRequest);
    end
    tick();
    total++;
    if ({mcuWriteAck, mcuFifoFull} !== 2'b11) begin
      bad++;
      $display("FAIL posted_fifth_ack: ack=%b full=%b want 1 1", mcuWriteAck, mcuFifoFull);
    end
    mcuWriteRequest = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({memoryWriteRequest, memoryAddress, memoryWriteData} !== {1'b1, 17'(16 + k), 8'(k)}) begin
        bad++;
        $display("FAIL posted_order %0d: wr=%b addr=%h data=%h want wr=1 addr=%h data=%h",
                 k, memoryWriteRequest, memoryAddress, memoryWriteData, 17'(16 + k), 8'(k));
      end
      memoryWriteComplete = 1'b1;
      tick();
      memoryWriteComplete = 1'b0;
      tick();
    end
    total++;
    if ({memoryWriteRequest, mcuFifoFull} !== 2'b00 || dut.fifoCount !== '0) begin
      bad++;
      $display("FAIL posted_drained: wr=%b full=%b count=%0d want 0 0 0",
               memoryWriteRequest, mcuFifoFull, dut.fifoCount);
    end
  endtask

  task automatic test_starvation();
    logic prevRd;
    logic rise;
    logic writeSeen;
    logic resumed;
    int   vidGrants;
    do_reset();
    vidAddress = 17'h00200;
    vidReadRequest = 1'b1;
    tick();
    mcuWriteRequest = 1'b1;
    mcuAddress = 17'h0FF00;
    mcuWriteData = 8'hA5;
    tick();
    total++;
    if (mcuWriteAck !== 1'b1) begin
      bad++;
      $display("FAIL starve_ack: got %b want 1", mcuWriteAck);
    end
    mcuWriteRequest = 1'b0;
    prevRd = 1'b1;
    writeSeen = 1'b0;
    resumed = 1'b0;
    vidGrants = 0;
    for (int c = 0; c < 80 && !resumed; c++) begin
      rise = memoryReadRequest && !prevRd;
      if (rise && writeSeen) resumed = 1'b1;
      else if (rise) vidGrants++;
      if (memoryWriteRequest && !writeSeen) begin
        writeSeen = 1'b1;
        total++;
        if (vidGrants != 8) begin
          bad++;
          $display("FAIL starve_video_run: grants=%0d want 8", vidGrants);
        end
        total++;
        if ({memoryAddress, memoryWriteData} !== {17'h0FF00, 8'hA5}) begin
          bad++;
          $display("FAIL starve_write_entry: addr=%h data=%h want 0ff00 a5", memoryAddress, memoryWriteData);
        end
      end
      memoryReadComplete = memoryReadRequest;
      memoryWriteComplete = memoryWriteRequest;
      prevRd = memoryReadRequest;
      if (!resumed) tick();
    end
    memoryReadComplete = 1'b0;
    memoryWriteComplete = 1'b0;
    total++;
    if ({writeSeen, resumed} !== 2'b11) begin
      bad++;
      $display("FAIL starve_timeout: writeSeen=%b resumed=%b want 1 1", writeSeen, resumed);
    end
    total++;
    if (dut.runCount !== '0) begin
      bad++;
      $display("FAIL starve_run_cleared: runCount=%0d want 0", dut.runCount);
    end
  endtask

  task automatic test_single_push();
    int acks;
    do_reset();
    vidAddress = 17'h00300;
    vidReadRequest = 1'b1;
    tick();
    mcuWriteRequest = 1'b1;
    mcuAddress = 17'h00050;
    mcuWriteData = 8'h77;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (mcuWriteAck === 1'b1) acks++;
    end
    total++;
    if (acks != 1) begin
      bad++;
      $display("FAIL single_push_acks: got %0d want 1", acks);
    end
    total++;
    if (dut.fifoCount !== 3'd1) begin
      bad++;
      $display("FAIL single_push_count: got %0d want 1", dut.fifoCount);
    end
    mcuWriteRequest = 1'b0;
    tick();
    mcuWriteRequest = 1'b1;
    mcuWriteData = 8'h78;
    tick();
    total++;
    if (mcuWriteAck !== 1'b1) begin
      bad++;
      $display("FAIL single_push_reassert_ack: got %b want 1", mcuWriteAck);
    end
    mcuWriteRequest = 1'b0;
    tick();
    total++;
    if (dut.fifoCount !== 3'd2) begin
      bad++;
      $display("FAIL single_push_reassert_count: got %0d want 2", dut.fifoCount);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    vidAddress = 17'h00400;
    vidReadRequest = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      mcuWriteRequest = 1'b1;
      mcuAddress = 17'(32 + i);
      mcuWriteData = 8'(64 + i);
      tick();
      mcuWriteRequest = 1'b0;
      tick();
    end
    memoryReadComplete = 1'b1;
    tick();
    memoryReadComplete = 1'b0;
    vidReadRequest = 1'b0;
    tick();
    total++;
    if (memoryWriteRequest !== 1'b1 || dut.fifoCount !== 3'd3) begin
      bad++;
      $display("FAIL midreset_setup: wr=%b count=%0d want 1 3", memoryWriteRequest, dut.fifoCount);
    end
    reset = 1'b0;
    tick();
    total++;
    if (memoryWriteRequest !== 1'b0) begin
      bad++;
      $display("FAIL midreset_req_drop: wr=%b want 0", memoryWriteRequest);
    end
    total++;
    if (dut.fifoCount !== '0 || mcuFifoFull !== 1'b0 || dut.state !== IDLE) begin
      bad++;
      $display("FAIL midreset_cleared: count=%0d full=%b state=%0d want 0 0 IDLE",
               dut.fifoCount, mcuFifoFull, dut.state);
    end
    reset = 1'b1;
    memoryWriteComplete = 1'b1;
    tick();
    memoryWriteComplete = 1'b0;
    tick();
    total++;
    if ({memoryWriteRequest, memoryReadRequest, mcuWriteAck} !== 3'b000 || dut.state !== IDLE) begin
      bad++;
      $display("FAIL midreset_spurious: wr=%b rd=%b ack=%b state=%0d want 0 0 0 IDLE",
               memoryWriteRequest, memoryReadRequest, mcuWriteAck, dut.state);
    end
  endtask

  initial begin
    test_reset();
    test_video_only();
    test_mcu_posted();
    test_starvation();
    test_single_push();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
